// File: rtl/sar_controller.sv
// sar_controller
// Successive-approximation control stage sitting right after the sample-and-hold.
// It drives the S/H track/hold clock, walks a binary-search trial code into the
// capacitive DAC, resolves one bit per trial from the synchronized comparator,
// and presents the finished code with a one-cycle valid strobe.
//
// Ports:
//   clk        tile clock, rising-edge
//   rst_n      asynchronous active-low reset
//   start      conversion request, level-sampled in IDLE or DONE
//   cont       continuous mode, sampled in DONE
//   cmp_in     asynchronous comparator output (1 = held input >= DAC level)
//   sample     S/H clock (1 = track, 0 = hold)
//   dac_code   trial code to the DAC
//   busy       high in SAMPLE and CONVERT
//   data_out   last completed result, held until the next DONE
//   data_valid one-cycle pulse coincident with DONE
//
// Handshake: data_valid is a pure valid strobe with no ready. The result is
// offered for exactly the DONE cycle; data_out keeps the value afterwards,
// so a consumer may sample it any time until the next data_valid.
//
// All outputs come straight from flops; nothing combinational reaches a port.
// The enum register `state` is the observable FSM state for bound checkers.
module sar_controller #(
  parameter int N             = 8,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         cont,
  input  logic         cmp_in,
  output logic         sample,
  output logic [N-1:0] dac_code,
  output logic         busy,
  output logic [N-1:0] data_out,
  output logic         data_valid
);

  localparam int CMAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int BW   = $clog2(N);

  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [BW-1:0] TOP_BIT     = BW'(N - 1);
  localparam logic [N-1:0]  TOP_TRIAL   = N'(1) << (N - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SAMPLE  = 2'd1,
    S_CONVERT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bit_idx, bit_idx_n;
  logic [N-1:0]  dac_n, data_out_n;
  logic          sample_n, busy_n, valid_n;
  logic          cmp_s1, cmp_s2;
  logic [BW-1:0] bit_dn;

  // Two-flop synchronizer; only cmp_s2 feeds decisions. With three settle
  // cycles, cmp_s2 in the last settle cycle reflects cmp_in at the end of
  // the first settle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_s1 <= 1'b0;
      cmp_s2 <= 1'b0;
    end else begin
      cmp_s1 <= cmp_in;
      cmp_s2 <= cmp_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      dac_code   <= '0;
      data_out   <= '0;
      sample     <= 1'b0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      dac_code   <= dac_n;
      data_out   <= data_out_n;
      sample     <= sample_n;
      busy       <= busy_n;
      data_valid <= valid_n;
    end
  end

  // Next-state and next-output logic. Output registers are loaded with the
  // value they must show in the state being entered.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    dac_n      = dac_code;
    data_out_n = data_out;
    sample_n   = 1'b0;
    busy_n     = 1'b0;
    valid_n    = 1'b0;
    bit_dn     = bit_idx - BW'(1);

    case (state)
      S_IDLE: begin
        dac_n = '0;
        if (start) begin
          state_n  = S_SAMPLE;
          cnt_n    = '0;
          sample_n = 1'b1;
          busy_n   = 1'b1;
        end
      end

      S_SAMPLE: begin
        busy_n = 1'b1;
        if (cnt == SAMPLE_LAST) begin
          // Falling edge of sample here is the hold instant.
          state_n   = S_CONVERT;
          cnt_n     = '0;
          bit_idx_n = TOP_BIT;
          dac_n     = TOP_TRIAL;
        end else begin
          cnt_n    = cnt + CW'(1);
          sample_n = 1'b1;
        end
      end

      S_CONVERT: begin
        busy_n = 1'b1;
        if (cnt == SETTLE_LAST) begin
          cnt_n          = '0;
          dac_n[bit_idx] = cmp_s2;
          if (bit_idx == '0) begin
            state_n    = S_DONE;
            busy_n     = 1'b0;
            valid_n    = 1'b1;
            data_out_n = dac_n;
          end else begin
            dac_n[bit_dn] = 1'b1;
            bit_idx_n     = bit_dn;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      S_DONE: begin
        dac_n = '0;
        cnt_n = '0;
        if (cont || start) begin
          state_n  = S_SAMPLE;
          sample_n = 1'b1;
          busy_n   = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end

      default: begin
        state_n = S_IDLE;
        dac_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_sar_controller.sv
// Bench for sar_controller at default parameters (N=8, 4 sample, 3 settle).
// The comparator is modelled as cmp_in = (vin >= dac_code). A timeline model
// (cycles since the accepted start) predicts every output every cycle, and a
// few literal expectations pin the model to known sequences.
module tb_sar_controller;

  localparam int N = 8;
  localparam int S = 4;
  localparam int T = 3;
  localparam int P = S + N*T + 1;   // DONE cycle number within a conversion

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         cont;
  logic         cmp_in;
  logic         sample;
  logic [N-1:0] dac_code;
  logic         busy;
  logic [N-1:0] data_out;
  logic         data_valid;

  logic [7:0]   vin;
  logic         glitch_en;
  logic         glitch_now;
  logic         glitch_val;

  int checks;
  int failures;

  sar_controller #(.N(N), .SAMPLE_CYCLES(S), .SETTLE_CYCLES(T)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cont       (cont),
    .cmp_in     (cmp_in),
    .sample     (sample),
    .dac_code   (dac_code),
    .busy       (busy),
    .data_out   (data_out),
    .data_valid (data_valid)
  );

  assign cmp_in = glitch_now ? glitch_val : (vin >= dac_code);

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_active;
  int         m_t;
  logic [7:0] m_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_t      = 0;
      m_data   = '0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_t      = 1;
      end
    end else if (m_t == P) begin
      if (cont || start) m_t = 1;
      else begin
        m_active = 1'b0;
        m_t      = 0;
      end
    end else begin
      m_t++;
      if (m_t == P) m_data = vin;
    end
  end

  function automatic logic [7:0] model_dac();
    int k, b, vv, d;
    if (!m_active || m_t <= S) return 8'h00;
    if (m_t == P) return m_data;
    k  = m_t - S - 1;
    b  = N - 1 - k / T;
    vv = int'(vin);
    d  = ((vv >> (b + 1)) << (b + 1)) | (1 << b);
    return 8'(d);
  endfunction

  // Comparator glitches confined to the first settle cycle of each bit.
  always @(posedge clk) begin
    #1;
    if (glitch_en && rst_n && m_active && m_t > S && m_t < P && ((m_t - S - 1) % T) == 0) begin
      glitch_now = 1'b1;
      glitch_val = 1'($urandom_range(0, 1));
      #1 glitch_val = ~glitch_val;
      #1 glitch_val = 1'($urandom_range(0, 1));
      #2 glitch_now = 1'b0;
    end
  end

  // ---------------- monitor + compare process ----------------
  int         start_edge;
  int         cycle_no;
  int         valid_cnt;
  int         valid_at;
  int         sample_cnt;
  logic [7:0] valid_data;
  logic [7:0] dac_seq [8];
  logic [7:0] exp_q [$];
  int         valid_abs_q [$];

  always @(negedge clk) begin
    if (rst_n) begin
      cycle_no = cyc - start_edge + 1;
      if (data_valid) begin
        valid_cnt++;
        valid_at   = cycle_no;
        valid_data = data_out;
        exp_q.push_back(data_out);
        valid_abs_q.push_back(cyc);
      end
      if (sample) sample_cnt++;
      for (int j = 0; j < 8; j++)
        if (cycle_no == S + 1 + T*j) dac_seq[j] = dac_code;
      chk("sample",     32'(sample),     32'(m_active && m_t <= S));
      chk("busy",       32'(busy),       32'(m_active && m_t < P));
      chk("data_valid", 32'(data_valid), 32'(m_active && m_t == P));
      chk("dac_code",   32'(dac_code),   32'(model_dac()));
      chk("data_out",   32'(data_out),   32'(m_data));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    valid_cnt  = 0;
    sample_cnt = 0;
    valid_at   = -1;
    valid_data = 8'hxx;
    exp_q.delete();
    valid_abs_q.delete();
    for (int j = 0; j < 8; j++) dac_seq[j] = 8'hxx;
  endtask

  task automatic go(input logic [7:0] v, input bit keep);
    vin = v;
    clear_stats();
    @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start_edge = cyc;
    if (!keep) start = 1'b0;
  endtask

  task automatic idle_wait(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input int n, input int budget);
    int k;
    k = 0;
    while (valid_cnt < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #2;
    chk("wait_valid_timeout", 32'(valid_cnt >= n), 32'd1);
  endtask

  task automatic single(input logic [7:0] v, input string name);
    go(v, 1'b0);
    idle_wait(35);
    chk({name, "_count"}, 32'(valid_cnt), 32'd1);
    chk({name, "_cycle"}, 32'(valid_at), 32'd29);
    chk({name, "_data"},  32'(valid_data), 32'(v));
  endtask

  // ---------------- main sequence ----------------
  logic [7:0] lit_seq [8];
  logic [7:0] rv;

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    cont       = 1'b0;
    vin        = 8'h00;
    glitch_en  = 1'b0;
    glitch_now = 1'b0;
    glitch_val = 1'b0;
    start_edge = 0;
    clear_stats();
    lit_seq[0] = 8'h80; lit_seq[1] = 8'hC0; lit_seq[2] = 8'hA0; lit_seq[3] = 8'hB0;
    lit_seq[4] = 8'hA8; lit_seq[5] = 8'hA4; lit_seq[6] = 8'hA6; lit_seq[7] = 8'hA5;

    #1;
    chk("rst_sample",   32'(sample),     32'd0);
    chk("rst_dac",      32'(dac_code),   32'd0);
    chk("rst_busy",     32'(busy),       32'd0);
    chk("rst_data_out", 32'(data_out),   32'd0);
    chk("rst_valid",    32'(data_valid), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    idle_wait(2);

    // Reference conversion of 0xA5 with literal trial sequence.
    go(8'hA5, 1'b0);
    idle_wait(35);
    chk("a5_count",      32'(valid_cnt),  32'd1);
    chk("a5_cycle",      32'(valid_at),   32'd29);
    chk("a5_data",       32'(valid_data), 32'hA5);
    chk("a5_sample_cyc", 32'(sample_cnt), 32'd4);
    for (int j = 0; j < 8; j++) chk($sformatf("a5_dac_seq%0d", j), 32'(dac_seq[j]), 32'(lit_seq[j]));

    // Extremes.
    single(8'h00, "vin00");
    single(8'hFF, "vinFF");
    single(8'h80, "vin80");

    // start held, then re-pulsed, during the conversion.
    go(8'h3C, 1'b1);
    repeat (18) @(posedge clk);
    #2 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    idle_wait(14);
    chk("hold_count", 32'(valid_cnt),  32'd1);
    chk("hold_cycle", 32'(valid_at),   32'd29);
    chk("hold_data",  32'(valid_data), 32'h3C);

    // Reset pulsed in cycle 15 of a conversion.
    go(8'h5A, 1'b0);
    repeat (14) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sample",   32'(sample),     32'd0);
    chk("midrst_dac",      32'(dac_code),   32'd0);
    chk("midrst_busy",     32'(busy),       32'd0);
    chk("midrst_data_out", 32'(data_out),   32'd0);
    chk("midrst_valid",    32'(data_valid), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    clear_stats();
    idle_wait(35);
    chk("midrst_no_valid", 32'(valid_cnt), 32'd0);
    chk("midrst_data_hold", 32'(data_out), 32'd0);
    rv = 8'($urandom_range(0, 255));
    single(rv, "post_rst");

    // Continuous mode: 0x11 then 0xEE, then cont cleared.
    cont = 1'b1;
    go(8'h11, 1'b0);
    wait_valid(1, 40);
    vin = 8'hEE;
    wait_valid(2, 40);
    cont = 1'b0;
    wait_valid(3, 40);
    idle_wait(40);
    chk("cont_count", 32'(valid_cnt), 32'd3);
    if (exp_q.size() >= 3 && valid_abs_q.size() >= 2) begin
      chk("cont_first",  32'(exp_q[0]), 32'h11);
      chk("cont_second", 32'(exp_q[1]), 32'hEE);
      chk("cont_third",  32'(exp_q[2]), 32'hEE);
      chk("cont_period", 32'(valid_abs_q[1] - valid_abs_q[0]), 32'd29);
    end else begin
      chk("cont_results_present", 32'(exp_q.size()), 32'd3);
    end
    chk("cont_idle_busy",   32'(busy),   32'd0);
    chk("cont_idle_sample", 32'(sample), 32'd0);

    // Random codes, alternating with comparator glitches in settle cycle 1.
    for (int i = 0; i < 10; i++) begin
      glitch_en = (i % 2) == 1;
      rv = 8'($urandom_range(0, 255));
      single(rv, glitch_en ? "rand_glitch" : "rand");
    end
    glitch_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
